// File: rtl/jam_cost_server_if.sv
// Cost-table load handshake between the table source and jam_cost_server.
interface jam_cost_server_if;
  logic       load_valid;
  logic [6:0] load_data;
  logic       load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/jam_cost_server.sv
// Cost table server for the JAM assignment engine: loads a 64-entry cost table,
// serves Cost for {W,J} combinationally, then captures the engine's final result.
module jam_cost_server #(
  parameter logic [19:0] SERVE_MAX = 20'hFFFFF
) (
  input  logic                 CLK,
  input  logic                 RST,
  jam_cost_server_if.slave     load,
  input  logic [2:0]           W,
  input  logic [2:0]           J,
  output logic [6:0]           Cost,
  input  logic [9:0]           MinCost,
  input  logic [3:0]           MatchCount,
  input  logic                 Valid,
  output logic                 serving,
  output logic                 result_valid,
  output logic [9:0]           result_min,
  output logic [3:0]           result_count,
  output logic [19:0]          serve_cycles,
  output logic                 proto_err
);

  typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

  state_t     state;
  logic [5:0] load_idx;
  logic [6:0] cost_tbl [64];

  // Table contents survive reset; only the load pointer restarts.
  always_ff @(posedge CLK) begin
    if (!RST && state == LOAD && load.load_valid)
      cost_tbl[load_idx] <= load.load_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= LOAD;
      load_idx        <= '0;
      load.load_ready <= 1'b1;
      serving         <= 1'b0;
      result_valid    <= 1'b0;
      result_min      <= '0;
      result_count    <= '0;
      serve_cycles    <= '0;
      proto_err       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (Valid)
            proto_err <= 1'b1;
          if (load.load_valid) begin
            load_idx <= load_idx + 6'd1;
            if (load_idx == 6'd63) begin
              state           <= SERVE;
              load.load_ready <= 1'b0;
              serving         <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (serve_cycles != SERVE_MAX)
            serve_cycles <= serve_cycles + 20'd1;
          if (Valid) begin
            result_min   <= MinCost;
            result_count <= MatchCount;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // serving is a registered copy of (state != LOAD), so it gates the read.
  always_comb begin
    Cost = '0;
    if (serving)
      Cost = cost_tbl[{W, J}];
  end

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: scoreboard queues for Cost reads and results.
module tb_jam_cost_server;

  localparam logic [19:0] SAT = 20'd2000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  W, J;
  logic [6:0]  Cost;
  logic [9:0]  MinCost;
  logic [3:0]  MatchCount;
  logic        Valid;
  logic        serving, result_valid, proto_err;
  logic [9:0]  result_min;
  logic [3:0]  result_count;
  logic [19:0] serve_cycles;

  always #5 CLK = ~CLK;

  jam_cost_server_if lif ();

  jam_cost_server #(.SERVE_MAX(SAT)) dut (
    .CLK(CLK), .RST(RST), .load(lif),
    .W(W), .J(J), .Cost(Cost),
    .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid),
    .serving(serving), .result_valid(result_valid),
    .result_min(result_min), .result_count(result_count),
    .serve_cycles(serve_cycles), .proto_err(proto_err)
  );

  int checks = 0;
  int passed = 0;

  logic [6:0]  src   [64];
  logic [6:0]  model [64];
  logic [6:0]  exp_cost_q [$];
  logic [13:0] exp_res_q  [$];

  localparam int CIC [64] = '{
    13, 21, 20, 12,  8, 26, 22, 11,
    12, 36, 25, 31, 15, 16, 30, 28,
    10, 30, 14, 14, 17, 15, 11, 20,
    29, 19, 23, 21, 33, 11, 26, 19,
    23, 17, 12, 19, 25, 27, 13, 23,
    15, 29, 19, 14, 21, 17, 28, 30,
    22, 14, 16, 26, 18, 21, 24, 12,
    27, 13, 30, 24, 22, 28, 16, 18};

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; lif.load_valid = 1'b0; Valid = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  // Drives transfers first..last; on gap cycles load_data carries junk.
  task automatic do_load(input bit gaps, input int first, input int last, input int valid_at);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        lif.load_valid = 1'b0; lif.load_data = 7'h55; tick();
      end
      lif.load_valid = 1'b1; lif.load_data = src[i]; Valid = (i == valid_at);
      model[i] = src[i];
      tick();
    end
    lif.load_valid = 1'b0; Valid = 1'b0;
  endtask

  // Brute-force minimum assignment over all 8! permutations of the model table.
  function automatic void golden(output int mn, output int cnt);
    int p[8];
    int s, i, j, t;
    bit more;
    mn = 1 << 30; cnt = 0; more = 1'b1;
    for (int k = 0; k < 8; k++) p[k] = k;
    while (more) begin
      s = 0;
      for (int w = 0; w < 8; w++) s += int'(model[w*8 + p[w]]);
      if (s < mn) begin mn = s; cnt = 1; end
      else if (s == mn) cnt++;
      i = 6;
      while (i >= 0 && p[i] > p[i+1]) i--;
      if (i < 0) more = 1'b0;
      else begin
        j = 7;
        while (p[j] < p[i]) j--;
        t = p[i]; p[i] = p[j]; p[j] = t;
        for (int a = i + 1, b = 7; a < b; a++, b--) begin
          t = p[a]; p[a] = p[b]; p[b] = t;
        end
      end
    end
  endfunction

  task automatic test_reset();
    W = 3'd0; J = 3'd0; MinCost = '0; MatchCount = '0; lif.load_data = '0;
    do_reset();
    checks++; if (lif.load_ready !== 1'b1) $display("FAIL reset_load_ready got=%b exp=1", lif.load_ready); else passed++;
    checks++; if (serving !== 1'b0) $display("FAIL reset_serving got=%b exp=0", serving); else passed++;
    checks++; if (Cost !== 7'd0) $display("FAIL reset_cost got=%0d exp=0", Cost); else passed++;
    checks++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid got=%b exp=0", result_valid); else passed++;
    checks++; if (result_min !== 10'd0 || result_count !== 4'd0)
      $display("FAIL reset_results got=%0d/%0d exp=0/0", result_min, result_count); else passed++;
    checks++; if (serve_cycles !== 20'd0) $display("FAIL reset_serve_cycles got=%0d exp=0", serve_cycles); else passed++;
    checks++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err got=%b exp=0", proto_err); else passed++;
  endtask

  task automatic test_load_nogap();
    logic [6:0] e;
    for (int i = 0; i < 64; i++) src[i] = 7'(i % 100);
    do_load(0, 0, 62, -1);
    W = 3'd3; J = 3'd5; #1;
    checks++; if (serving !== 1'b0 || Cost !== 7'd0)
      $display("FAIL nogap_pre_serve serving=%b cost=%0d exp=0/0", serving, Cost); else passed++;
    do_load(0, 63, 63, -1);
    checks++; if (serving !== 1'b1 || lif.load_ready !== 1'b0)
      $display("FAIL nogap_serving serving=%b ready=%b exp=1/0", serving, lif.load_ready); else passed++;
    checks++; if (serve_cycles !== 20'd0) $display("FAIL nogap_sc0 got=%0d exp=0", serve_cycles); else passed++;
    W = 3'd3; J = 3'd5; exp_cost_q.push_back(7'd29); #1;
    e = exp_cost_q.pop_front();
    checks++; if (Cost !== e) $display("FAIL nogap_cost_3_5 got=%0d exp=%0d", Cost, e); else passed++;
    // load_valid in SERVE must not disturb the table
    lif.load_valid = 1'b1; lif.load_data = 7'd127;
    tick(); tick(); tick();
    lif.load_valid = 1'b0;
    checks++; if (serve_cycles !== 20'd3) $display("FAIL nogap_sc3 got=%0d exp=3", serve_cycles); else passed++;
    for (int k = 0; k < 64; k++) begin
      W = k[5:3]; J = k[2:0]; exp_cost_q.push_back(model[k]); #1;
      e = exp_cost_q.pop_front();
      checks++; if (Cost !== e) $display("FAIL nogap_sweep idx=%0d got=%0d exp=%0d", k, Cost, e); else passed++;
      tick();
    end
  endtask

  task automatic test_load_gap();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 64; i++) model[i] = 7'h7F;
    do_load(1, 0, 62, -1);
    checks++; if (serving !== 1'b0 || lif.load_ready !== 1'b1)
      $display("FAIL gap_cycle126 serving=%b ready=%b exp=0/1", serving, lif.load_ready); else passed++;
    do_load(1, 63, 63, -1);
    checks++; if (serving !== 1'b1) $display("FAIL gap_cycle128 serving=%b exp=1", serving); else passed++;
    for (int k = 0; k < 64; k++) begin
      W = k[5:3]; J = k[2:0]; exp_cost_q.push_back(7'(k % 100)); #1;
      e = exp_cost_q.pop_front();
      checks++; if (Cost !== e) $display("FAIL gap_sweep idx=%0d got=%0d exp=%0d", k, Cost, e); else passed++;
      tick();
    end
  endtask

  task automatic test_jam();
    logic [6:0]  e;
    logic [13:0] r;
    int gm, gc;
    bit got;
    do_reset();
    for (int i = 0; i < 64; i++) src[i] = 7'(CIC[i]);
    do_load(0, 0, 63, -1);
    for (int k = 0; k < 64; k++) begin
      W = k[5:3]; J = k[2:0]; exp_cost_q.push_back(model[k]); #1;
      e = exp_cost_q.pop_front();
      checks++; if (Cost !== e) $display("FAIL jam_sweep idx=%0d got=%0d exp=%0d", k, Cost, e); else passed++;
      tick();
    end
    golden(gm, gc);
    MinCost = 10'(gm); MatchCount = 4'(gc); Valid = 1'b1;
    exp_res_q.push_back({10'(gm), 4'(gc)});
    tick();
    Valid = 1'b0; MinCost = '0; MatchCount = '0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      if (result_valid === 1'b1) got = 1'b1; else tick();
    end
    checks++; if (!got) $display("FAIL jam_result_valid timeout got=%b exp=1", result_valid); else passed++;
    r = exp_res_q.pop_front();
    checks++; if (result_min !== r[13:4] || result_count !== r[3:0])
      $display("FAIL jam_result got=%0d/%0d exp=%0d/%0d", result_min, result_count, r[13:4], r[3:0]); else passed++;
    checks++; if (serve_cycles !== 20'd65 || !(serve_cycles < SAT))
      $display("FAIL jam_serve_cycles got=%0d exp=65", serve_cycles); else passed++;
  endtask

  task automatic test_proto_err();
    logic [13:0] r;
    do_reset();
    for (int i = 0; i < 64; i++) src[i] = 7'(i % 100);
    do_load(0, 0, 62, 10);
    checks++; if (proto_err !== 1'b1 || serving !== 1'b0)
      $display("FAIL proto_err_in_load proto=%b serving=%b exp=1/0", proto_err, serving); else passed++;
    do_load(0, 63, 63, -1);
    checks++; if (serving !== 1'b1) $display("FAIL proto_load_continues serving=%b exp=1", serving); else passed++;
    MinCost = 10'd100; MatchCount = 4'd3; Valid = 1'b1;
    exp_res_q.push_back({10'd100, 4'd3});
    tick();
    Valid = 1'b0;
    r = exp_res_q.pop_front();
    checks++; if (result_valid !== 1'b1 || result_min !== r[13:4] || result_count !== r[3:0])
      $display("FAIL proto_capture got=%b %0d/%0d exp=1 %0d/%0d", result_valid, result_min, result_count, r[13:4], r[3:0]); else passed++;
    tick(); tick(); tick();
    MinCost = 10'd555; MatchCount = 4'd9; Valid = 1'b1;
    tick();
    Valid = 1'b0;
    tick();
    checks++; if (result_min !== 10'd100 || result_count !== 4'd3)
      $display("FAIL done_second_valid got=%0d/%0d exp=100/3", result_min, result_count); else passed++;
    checks++; if (serve_cycles !== 20'd1) $display("FAIL done_sc_frozen got=%0d exp=1", serve_cycles); else passed++;
    checks++; if (proto_err !== 1'b1) $display("FAIL proto_sticky got=%b exp=1", proto_err); else passed++;
  endtask

  task automatic test_rst_midload();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 64; i++) src[i] = 7'(i % 100);
    do_load(0, 0, 29, -1);
    // reset must win over a simultaneous transfer and Valid
    RST = 1'b1; lif.load_valid = 1'b1; lif.load_data = 7'd99; Valid = 1'b1;
    tick();
    RST = 1'b0; lif.load_valid = 1'b0; Valid = 1'b0;
    W = 3'd0; J = 3'd1; #1;
    checks++; if (lif.load_ready !== 1'b1 || serving !== 1'b0 || proto_err !== 1'b0 || Cost !== 7'd0)
      $display("FAIL midload_rst ready=%b serving=%b proto=%b cost=%0d exp=1/0/0/0",
               lif.load_ready, serving, proto_err, Cost); else passed++;
    for (int i = 0; i < 64; i++) src[i] = 7'd7;
    do_load(0, 0, 62, -1);
    checks++; if (serving !== 1'b0) $display("FAIL reload_restart_idx serving=%b exp=0", serving); else passed++;
    do_load(0, 63, 63, -1);
    checks++; if (serving !== 1'b1 || serve_cycles !== 20'd0)
      $display("FAIL reload_serving serving=%b sc=%0d exp=1/0", serving, serve_cycles); else passed++;
    for (int k = 0; k < 64; k++) begin
      W = k[5:3]; J = k[2:0]; exp_cost_q.push_back(7'd7); #1;
      e = exp_cost_q.pop_front();
      checks++; if (Cost !== e) $display("FAIL reload7_sweep idx=%0d got=%0d exp=%0d", k, Cost, e); else passed++;
      tick();
    end
    checks++; if (serve_cycles !== 20'd64) $display("FAIL reload_sc got=%0d exp=64", serve_cycles); else passed++;
    RST = 1'b1; tick(); RST = 1'b0;
    W = 3'd3; J = 3'd5; #1;
    checks++; if (serving !== 1'b0 || Cost !== 7'd0 || serve_cycles !== 20'd0)
      $display("FAIL midserve_rst serving=%b cost=%0d sc=%0d exp=0/0/0", serving, Cost, serve_cycles); else passed++;
    for (int i = 0; i < 64; i++) src[i] = 7'(i % 100);
    do_load(0, 0, 63, -1);
    W = 3'd3; J = 3'd5; exp_cost_q.push_back(7'd29); #1;
    e = exp_cost_q.pop_front();
    checks++; if (Cost !== e) $display("FAIL midserve_reload got=%0d exp=%0d", Cost, e); else passed++;
  endtask

  task automatic test_saturation();
    logic [13:0] r;
    do_reset();
    do_load(0, 0, 63, -1);
    for (int t = 0; t < int'(SAT) + 5; t++) tick();
    checks++; if (serve_cycles !== SAT) $display("FAIL sat_hold got=%0d exp=%0d", serve_cycles, SAT); else passed++;
    MinCost = 10'd321; MatchCount = 4'd5; Valid = 1'b1;
    exp_res_q.push_back({10'd321, 4'd5});
    tick(); Valid = 1'b0;
    r = exp_res_q.pop_front();
    checks++; if (result_valid !== 1'b1 || result_min !== r[13:4] || result_count !== r[3:0] || serve_cycles !== SAT)
      $display("FAIL sat_capture got=%b %0d/%0d sc=%0d exp=1 %0d/%0d sc=%0d",
               result_valid, result_min, result_count, serve_cycles, r[13:4], r[3:0], SAT); else passed++;
    do_reset();
    do_load(0, 0, 63, -1);
    for (int t = 0; t < int'(SAT) - 1; t++) tick();
    checks++; if (serve_cycles !== SAT - 20'd1) $display("FAIL sat_pre got=%0d exp=%0d", serve_cycles, SAT - 20'd1); else passed++;
    MinCost = 10'd200; MatchCount = 4'd2; Valid = 1'b1;
    exp_res_q.push_back({10'd200, 4'd2});
    tick(); Valid = 1'b0;
    r = exp_res_q.pop_front();
    checks++; if (result_valid !== 1'b1 || result_min !== r[13:4] || result_count !== r[3:0] || serve_cycles !== SAT)
      $display("FAIL sat_same_edge got=%b %0d/%0d sc=%0d exp=1 %0d/%0d sc=%0d",
               result_valid, result_min, result_count, serve_cycles, r[13:4], r[3:0], SAT); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; lif.load_valid = 1'b0; lif.load_data = '0; Valid = 1'b0;
    test_reset();
    test_load_nogap();
    test_load_gap();
    test_jam();
    test_proto_err();
    test_rst_midload();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
